// File: rtl/pair_stream_deserializer_if.sv
// Output handshake bundle for the pair stream deserializer: one lane-A/lane-B
// word pair per transfer, moved when out_valid and out_ready are both high.
interface pair_stream_deserializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_a,
        output out_b,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_a,
        input  out_b,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pair_stream_deserializer.sv
// Samples an upstream divided phase and its multiplexed serial bit as plain data,
// rebuilds WIDTH-bit lane-A/lane-B word pairs and queues them in a small FIFO.
module pair_stream_deserializer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        phase_in,
    input  logic                        bit_in,
    pair_stream_deserializer_if.master  out_if,
    output logic                        overflow,
    output logic                        stall
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        WAIT_B = 2'd1,
        WAIT_A = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                 phase_prev;
    logic                 rise;
    logic                 fall;
    logic [WIDTH-1:0]     sh_a;
    logic [WIDTH-1:0]     sh_b;
    logic [CW-1:0]        bit_cnt;
    logic [CW-1:0]        bit_cnt_next;
    logic [IW-1:0]        idle_cnt;
    logic [IW-1:0]        idle_cnt_next;
    logic                 shift_a;
    logic                 shift_b;
    logic                 push;
    logic                 timeout_hit;
    logic [2*WIDTH-1:0]   pair_word;

    logic [2*WIDTH-1:0]   mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [NW-1:0]        count;
    logic                 pop;
    logic                 full;
    logic                 push_ok;
    logic [2*WIDTH-1:0]   head;

    assign rise = phase_in & ~phase_prev;
    assign fall = ~phase_in & phase_prev;

    // The completing fall's bit is not yet in sh_b, so splice it in directly.
    assign pair_word = {sh_a, sh_b[WIDTH-2:0], bit_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        idle_cnt_next = '0;
        shift_a       = 1'b0;
        shift_b       = 1'b0;
        push          = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            HUNT: begin
                if (en && rise) begin
                    shift_a      = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = WAIT_B;
                end
            end
            WAIT_B, WAIT_A: begin
                if (!en) begin
                    bit_cnt_next = '0;
                    state_next   = HUNT;
                end else if (rise || fall) begin
                    if (state == WAIT_B && fall) begin
                        shift_b    = 1'b1;
                        state_next = WAIT_A;
                        if (bit_cnt == CW'(WIDTH - 1)) begin
                            push         = 1'b1;
                            bit_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt + 1'b1;
                        end
                    end else if (state == WAIT_A && rise) begin
                        shift_a    = 1'b1;
                        state_next = WAIT_B;
                    end
                end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
                    // This quiet cycle is the TIMEOUT-th one since the last edge.
                    timeout_hit  = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = HUNT;
                end else begin
                    idle_cnt_next = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_prev <= 1'b0;
            sh_a       <= '0;
            sh_b       <= '0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            stall      <= 1'b0;
        end else begin
            phase_prev <= phase_in;
            if (shift_a) begin
                sh_a <= {sh_a[WIDTH-2:0], bit_in};
            end
            if (shift_b) begin
                sh_b <= {sh_b[WIDTH-2:0], bit_in};
            end
            bit_cnt  <= bit_cnt_next;
            idle_cnt <= idle_cnt_next;
            if (timeout_hit) begin
                stall <= 1'b1;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop     = (count != '0) && out_if.out_ready;
    assign full    = (count == NW'(DEPTH));
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr] <= pair_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head             = mem[rd_ptr];
    assign out_if.out_valid = (count != '0);
    assign out_if.out_a     = (count != '0) ? head[2*WIDTH-1:WIDTH] : '0;
    assign out_if.out_b     = (count != '0) ? head[WIDTH-1:0] : '0;

endmodule

// File: tb/tb_pair_stream_deserializer.sv
// Drives phase/bit streams built from intended word pairs and compares every
// cycle against a queue-based model of the output FIFO, overflow and stall.
module tb_pair_stream_deserializer;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic phase_in = 1'b0;
    logic bit_in = 1'b0;
    logic overflow;
    logic stall;

    pair_stream_deserializer_if #(.WIDTH(WIDTH)) bus ();

    pair_stream_deserializer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .phase_in (phase_in),
        .bit_in   (bit_in),
        .out_if   (bus),
        .overflow (overflow),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    logic [2*WIDTH-1:0] exp_q[$];
    bit   exp_ovf;
    bit   exp_stall;
    bit   synced;
    int   quiet;
    logic mprev;
    logic cur_ph;
    int   rdy_mode;
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkModel();
        logic [2*WIDTH-1:0] head;
        head = '0;
        if (exp_q.size() != 0) head = exp_q[0];
        checkOutput("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        checkOutput("out_a", 32'(bus.out_a), 32'(head[2*WIDTH-1:WIDTH]));
        checkOutput("out_b", 32'(bus.out_b), 32'(head[WIDTH-1:0]));
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
        checkOutput("stall", 32'(stall), 32'(exp_stall));
    endtask

    // One clock of stimulus; the model predicts the effect of this posedge.
    task automatic applyStimulus(input logic ph, input logic b, input logic e,
                                 input bit completes, input logic [2*WIDTH-1:0] pair);
        logic rdy;
        bit   pop;
        int   sz;
        bit   edge_seen;
        bit   rise_seen;
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = completes;
        endcase
        phase_in      = ph;
        bit_in        = b;
        en            = e;
        bus.out_ready = rdy;
        cur_ph        = ph;

        sz  = exp_q.size();
        pop = (sz != 0) && rdy;
        if (pop) void'(exp_q.pop_front());
        if (completes) begin
            if (sz < DEPTH || pop) exp_q.push_back(pair);
            else exp_ovf = 1'b1;
        end

        edge_seen = (ph != mprev);
        rise_seen = ph && !mprev;
        if (!e) begin
            synced = 1'b0;
        end else if (synced) begin
            if (edge_seen) begin
                quiet = 0;
            end else begin
                quiet++;
                if (quiet == TIMEOUT) begin
                    exp_stall = 1'b1;
                    synced    = 1'b0;
                end
            end
        end else if (rise_seen) begin
            synced = 1'b1;
            quiet  = 0;
        end
        mprev = ph;

        @(posedge clk);
        @(negedge clk);
        checkModel();
    endtask

    task automatic doReset();
        exp_q.delete();
        exp_ovf   = 1'b0;
        exp_stall = 1'b0;
        synced    = 1'b0;
        quiet     = 0;
        reset     = 1'b1;
        en        = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            phase_in = ~phase_in;
            bit_in   = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("rst_out_a", 32'(bus.out_a), 32'd0);
            checkOutput("rst_out_b", 32'(bus.out_b), 32'd0);
            checkOutput("rst_overflow", 32'(overflow), 32'd0);
            checkOutput("rst_stall", 32'(stall), 32'd0);
        end
        reset    = 1'b0;
        phase_in = 1'b0;
        cur_ph   = 1'b0;
        mprev    = 1'b0;
    endtask

    // Sends one pair MSB first starting from phase low; abort_at drops en mid-word.
    task automatic sendPair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input int hold_max, input int abort_at);
        int h;
        for (int i = 0; i < WIDTH; i++) begin
            h = $urandom_range(1, hold_max);
            for (int j = 0; j < h; j++)
                applyStimulus(1'b1, (j == 0) ? a[WIDTH-1-i] : 1'($urandom), 1'b1, 1'b0, '0);
            if (i == abort_at) begin
                applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0, '0);
                applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0, '0);
                return;
            end
            h = $urandom_range(1, hold_max);
            for (int j = 0; j < h; j++)
                applyStimulus(1'b0, (j == 0) ? b[WIDTH-1-i] : 1'($urandom), 1'b1,
                              (i == WIDTH - 1) && (j == 0), {a, b});
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(cur_ph, 1'($urandom), 1'b1, 1'b0, '0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int abort_at;
        bus.out_ready = 1'b0;
        rdy_mode = 1;

        doReset();
        sendPair(8'hA5, 8'h3C, 1, -1);
        idleCycles(3);

        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        sendPair(8'hA5, 8'h3C, 1, -1);
        idleCycles(3);

        doReset();
        rdy_mode = 0;
        for (int k = 1; k <= 5; k++)
            sendPair(WIDTH'(k), WIDTH'(8'h80 + k), 2, -1);
        idleCycles(2);
        rdy_mode = 1;
        idleCycles(8);

        doReset();
        rdy_mode = 0;
        for (int k = 1; k <= 4; k++)
            sendPair(WIDTH'(8'h10 + k), WIDTH'(8'h90 + k), 1, -1);
        rdy_mode = 3;
        sendPair(8'h55, 8'hD5, 1, -1);
        rdy_mode = 1;
        idleCycles(8);

        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'($urandom), 1'b1, 1'b0, '0);
            applyStimulus(1'b0, 1'($urandom), 1'b1, 1'b0, '0);
        end
        idleCycles(TIMEOUT + 4);
        sendPair(8'hC3, 8'h69, 2, -1);
        idleCycles(3);

        doReset();
        sendPair(8'hFF, 8'hFF, 1, 3);
        idleCycles(1);
        sendPair(8'h0F, 8'hF0, 2, -1);
        idleCycles(3);

        doReset();
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
            sendPair(ra, rb, 3, abort_at);
            if ($urandom_range(0, 9) == 0) idleCycles(int'($urandom_range(1, 24)));
        end
        rdy_mode = 1;
        idleCycles(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
